// File: rtl/minmax_tracker_3_bit_pkg.sv
// Shared state encoding and default sizing for the 3-bit min/max frame tracker.
package minmax_tracker_3_bit_pkg;

   localparam int DEFAULT_WIDTH     = 3;
   localparam int DEFAULT_FRAME_LEN = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FIRST = 2'd1,
      ACCUM = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/Comparator_3_bit.sv
// 3-bit unsigned magnitude comparator: exactly one of L (A<B), E (A==B), G (A>B) is high.
module Comparator_3_bit (
   input  logic [2:0] A,
   input  logic [2:0] B,
   output logic       L,
   output logic       E,
   output logic       G
);

   assign L = (A <  B);
   assign E = (A == B);
   assign G = (A >  B);

endmodule

// File: rtl/minmax_tracker_3_bit.sv
// Tracks running max/min and sample count over a frame of FRAME_LEN samples.
// Optional MINMAX_TIE_COUNT_EN adds tie_cnt: occurrences of the current maximum.
module minmax_tracker_3_bit
   import minmax_tracker_3_bit_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int FRAME_LEN = DEFAULT_FRAME_LEN,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic [WIDTH-1:0] max_out,
   output logic [WIDTH-1:0] min_out,
   output logic [CNT_W-1:0] sample_cnt,
   output logic             busy,
   output logic             done
`ifdef MINMAX_TIE_COUNT_EN
   ,
   output logic [CNT_W-1:0] tie_cnt
`endif
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             xfer_s;
   logic             a_l_s, a_e_s, a_g_s;
   logic             b_l_s, b_e_s, b_g_s;
`ifdef MINMAX_TIE_COUNT_EN
   logic [CNT_W-1:0] tie_q, tie_d;
   logic             unused_s;
   assign unused_s = ^{a_l_s, b_e_s, b_g_s};
`else
   logic             unused_s;
   assign unused_s = ^{a_l_s, a_e_s, b_e_s, b_g_s};
`endif

   // Max path: sample vs current max; min path: sample vs current min.
   Comparator_3_bit u_cmp_max (.A(in_data), .B(max_q), .L(a_l_s), .E(a_e_s), .G(a_g_s));
   Comparator_3_bit u_cmp_min (.A(in_data), .B(min_q), .L(b_l_s), .E(b_e_s), .G(b_g_s));

   assign xfer_s    = in_valid & in_ready_q;
   assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state, datapath update and decode of the next registered flags.
   always_comb begin
      state_d = state_q;
      max_d   = max_q;
      min_d   = min_q;
      cnt_d   = cnt_q;
`ifdef MINMAX_TIE_COUNT_EN
      tie_d   = tie_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FIRST;
               cnt_d   = {CNT_W{1'b0}};
`ifdef MINMAX_TIE_COUNT_EN
               tie_d   = {CNT_W{1'b0}};
`endif
            end else begin
               state_d = IDLE;
            end
         end
         FIRST: begin
            if (xfer_s) begin
               max_d   = in_data;
               min_d   = in_data;
               cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MINMAX_TIE_COUNT_EN
               tie_d   = {{(CNT_W-1){1'b0}}, 1'b1};
`endif
               state_d = (FRAME_LEN == 1) ? DONE : ACCUM;
            end else begin
               state_d = FIRST;
            end
         end
         ACCUM: begin
            if (xfer_s) begin
               if (a_g_s) begin
                  max_d = in_data;
               end else begin
                  max_d = max_q;
               end
               if (b_l_s) begin
                  min_d = in_data;
               end else begin
                  min_d = min_q;
               end
`ifdef MINMAX_TIE_COUNT_EN
               if (a_g_s) begin
                  tie_d = {{(CNT_W-1){1'b0}}, 1'b1};
               end else if (a_e_s) begin
                  tie_d = tie_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  tie_d = tie_q;
               end
`endif
               cnt_d = cnt_inc_s;
               if (cnt_inc_s == CNT_W'(FRAME_LEN)) begin
                  state_d = DONE;
               end else begin
                  state_d = ACCUM;
               end
            end else begin
               state_d = ACCUM;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d = (state_d == FIRST) || (state_d == ACCUM);
      busy_d     = (state_d == FIRST) || (state_d == ACCUM);
      done_d     = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         max_q      <= {WIDTH{1'b0}};
         min_q      <= {WIDTH{1'b0}};
         cnt_q      <= {CNT_W{1'b0}};
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MINMAX_TIE_COUNT_EN
         tie_q      <= {CNT_W{1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         max_q      <= max_d;
         min_q      <= min_d;
         cnt_q      <= cnt_d;
         in_ready_q <= in_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef MINMAX_TIE_COUNT_EN
         tie_q      <= tie_d;
`endif
      end
   end

   assign in_ready   = in_ready_q;
   assign max_out    = max_q;
   assign min_out    = min_q;
   assign sample_cnt = cnt_q;
   assign busy       = busy_q;
   assign done       = done_q;
`ifdef MINMAX_TIE_COUNT_EN
   assign tie_cnt    = tie_q;
`endif

endmodule

// File: tb/tb_minmax_tracker_3_bit.sv
// Scoreboard bench for minmax_tracker_3_bit (FRAME_LEN=8 instance plus a FRAME_LEN=1 instance).
module tb_minmax_tracker_3_bit;

   localparam int FL = 8;
   localparam int CW = 4;

   typedef logic [2:0] frame_t [FL];
   typedef struct {
      int mx;
      int mn;
      int cnt;
      int tie;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, in_valid;
   logic [2:0]    in_data;
   logic          in_ready, busy, done;
   logic [2:0]    max_out, min_out;
   logic [CW-1:0] sample_cnt;
`ifdef MINMAX_TIE_COUNT_EN
   logic [CW-1:0] tie_cnt;
   logic [CW-1:0] tie_cnt1;
`endif

   logic          start1, in_valid1;
   logic [2:0]    in_data1;
   logic          in_ready1, busy1, done1;
   logic [2:0]    max_out1, min_out1;
   logic [CW-1:0] sample_cnt1;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_done  = 0;
   int   n_sent  = 0;
   int   last_max = 0;
   int   last_min = 0;

   always #5 clk = ~clk;

   minmax_tracker_3_bit #(.WIDTH(3), .FRAME_LEN(FL), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .max_out(max_out), .min_out(min_out), .sample_cnt(sample_cnt),
      .busy(busy), .done(done)
`ifdef MINMAX_TIE_COUNT_EN
      , .tie_cnt(tie_cnt)
`endif
   );

   minmax_tracker_3_bit #(.WIDTH(3), .FRAME_LEN(1), .CNT_W(CW)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .in_valid(in_valid1), .in_data(in_data1),
      .in_ready(in_ready1), .max_out(max_out1), .min_out(min_out1), .sample_cnt(sample_cnt1),
      .busy(busy1), .done(done1)
`ifdef MINMAX_TIE_COUNT_EN
      , .tie_cnt(tie_cnt1)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Pop the scoreboard whenever the DUT reports a completed frame.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         exp_t e;
         n_done++;
         chk("done_ready_low", {31'd0, in_ready}, 32'd0);
         chk("done_busy_low", {31'd0, busy}, 32'd0);
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_done", sb_q.size(), 32'd1);
         end else begin
            e = sb_q.pop_front();
            chk("sb_max", {29'd0, max_out}, e.mx);
            chk("sb_min", {29'd0, min_out}, e.mn);
            chk("sb_cnt", {28'd0, sample_cnt}, e.cnt);
`ifdef MINMAX_TIE_COUNT_EN
            chk("sb_tie", {28'd0, tie_cnt}, e.tie);
`endif
         end
      end
   end

   task automatic send_frame(input frame_t d, input bit gaps, input bit start_mid);
      exp_t e;
      int   idx;
      int   cyc;
      e.mx = 0;
      e.mn = 7;
      e.cnt = FL;
      e.tie = 0;
      for (int i = 0; i < FL; i++) begin
         if (int'(d[i]) > e.mx) e.mx = int'(d[i]);
         if (int'(d[i]) < e.mn) e.mn = int'(d[i]);
      end
      for (int i = 0; i < FL; i++) begin
         if (int'(d[i]) == e.mx) e.tie++;
      end
      sb_q.push_back(e);
      n_sent++;

      @(negedge clk);
      chk("idle_ready_low", {31'd0, in_ready}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("first_cnt_clear", {28'd0, sample_cnt}, 32'd0);
      chk("first_busy", {31'd0, busy}, 32'd1);
      chk("hold_prev_max", {29'd0, max_out}, last_max);
      chk("hold_prev_min", {29'd0, min_out}, last_min);

      idx = 0;
      cyc = 0;
      while (idx < FL && cyc < 200) begin
         in_valid = gaps ? ~cyc[0] : 1'b1;
         in_data  = d[idx];
         start    = start_mid && (idx == 4);
         if (in_valid && in_ready) idx++;
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      start    = 1'b0;
      chk("xfer_count", idx, FL);
      chk("done_latency", {31'd0, done}, 32'd1);

      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      chk("idle_busy_low", {31'd0, busy}, 32'd0);
      chk("idle_ready_after", {31'd0, in_ready}, 32'd0);
      repeat (3) @(negedge clk);
      chk("no_extra_frame", {31'd0, busy}, 32'd0);
      chk("frames_done", n_done, n_sent);
      last_max = e.mx;
      last_min = e.mn;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t f;
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_data = 3'd0;
      start1 = 1'b0;
      in_valid1 = 1'b0;
      in_data1 = 3'd0;
      repeat (2) @(negedge clk);
      chk("rst_max", {29'd0, max_out}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      // Basic frame, then the same data with gaps.
      f = '{3'd3, 3'd5, 3'd1, 3'd7, 3'd2, 3'd2, 3'd6, 3'd4};
      send_frame(f, 1'b0, 1'b0);
      send_frame(f, 1'b1, 1'b0);

      f = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7};
      send_frame(f, 1'b0, 1'b0);

      f = '{3'd4, 3'd2, 3'd6, 3'd6, 3'd3, 3'd5, 3'd1, 3'd2};
      send_frame(f, 1'b0, 1'b1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < FL; i++) f[i] = 3'($urandom_range(0, 7));
         send_frame(f, r[0], 1'b0);
      end

      // Reset in the middle of ACCUM with in_valid held high.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 3'd6;
      repeat (3) @(negedge clk);
      chk("pre_reset_cnt", {28'd0, sample_cnt}, 32'd3);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_max", {29'd0, max_out}, 32'd0);
      chk("midrst_min", {29'd0, min_out}, 32'd0);
      chk("midrst_cnt", {28'd0, sample_cnt}, 32'd0);
      chk("midrst_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b0;
      last_max = 0;
      last_min = 0;
      f = '{3'd2, 3'd1, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2};
      send_frame(f, 1'b0, 1'b0);

      // Single-sample frame instance.
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      in_valid1 = 1'b1;
      in_data1 = 3'd5;
      chk("fl1_ready", {31'd0, in_ready1}, 32'd1);
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("fl1_done", {31'd0, done1}, 32'd1);
      chk("fl1_max", {29'd0, max_out1}, 32'd5);
      chk("fl1_min", {29'd0, min_out1}, 32'd5);
      chk("fl1_cnt", {28'd0, sample_cnt1}, 32'd1);
      chk("fl1_done_ready", {31'd0, in_ready1}, 32'd0);
      @(negedge clk);
      chk("fl1_done_pulse", {31'd0, done1}, 32'd0);
      chk("fl1_idle", {31'd0, busy1}, 32'd0);

      chk("sb_drained", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
